// File: rtl/uart_rx_pkg.sv
// Shared types for the UART RX path: frame checker FSM states and parity-type encodings.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAR  = 2'd1,
    ST_STP  = 2'd2,
    ST_DONE = 2'd3
  } chk_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Expected parity bit given the XOR-reduction of the data word.
  function automatic logic par_expected(input logic data_xor, input logic par_typ);
    return data_xor ^ par_typ;
  endfunction

endpackage

// File: rtl/frame_chk_if.sv
// Bundle between the RX sampler/deserializer (master) and the frame checker (slave).
interface frame_chk_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_STOP      = 2,
  parameter int ERR_CNT_WIDTH = 8
);
  localparam int STP_CNT_W = $clog2(MAX_STOP + 1);

  logic                     frame_start;
  logic                     sampled_bit;
  logic [DATA_WIDTH-1:0]    P_DATA;
  logic                     PAR_EN;
  logic                     PAR_TYP;
  logic [STP_CNT_W-1:0]     STP_NUM;
  logic                     par_chk_en;
  logic                     stp_chk_en;
  logic                     cnt_clr;
  logic                     par_err;
  logic                     stp_err;
  logic                     brk_det;
  logic                     frame_done;
  logic                     frame_ok;
  logic [ERR_CNT_WIDTH-1:0] par_err_cnt;
  logic [ERR_CNT_WIDTH-1:0] stp_err_cnt;

  modport master (
    output frame_start, sampled_bit, P_DATA, PAR_EN, PAR_TYP, STP_NUM,
           par_chk_en, stp_chk_en, cnt_clr,
    input  par_err, stp_err, brk_det, frame_done, frame_ok, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  frame_start, sampled_bit, P_DATA, PAR_EN, PAR_TYP, STP_NUM,
           par_chk_en, stp_chk_en, cnt_clr,
    output par_err, stp_err, brk_det, frame_done, frame_ok, par_err_cnt, stp_err_cnt
  );

endinterface

// File: rtl/frame_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over a simultaneous increment.
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/frame_chk.sv
// UART RX frame checker: parity, 1..MAX_STOP stop bits, break detect, sticky flags, frame_done pulse.
// Optional per-flag saturating error counters under FRAME_CHK_ERR_CNT_EN (tied to 0 otherwise).
module frame_chk
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_STOP      = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic      CLK,
  input  logic      RST,
  frame_chk_if.slave bus
);

  localparam int                   STP_CNT_W = $clog2(MAX_STOP + 1);
  localparam logic [STP_CNT_W-1:0] STP_MAX   = STP_CNT_W'(MAX_STOP);
  localparam logic [STP_CNT_W-1:0] STP_ONE   = STP_CNT_W'(1);

  chk_state_e           state_q, state_d;
  logic                 par_en_q, par_en_d;
  logic                 par_typ_q, par_typ_d;
  logic                 par_bit_q, par_bit_d;
  logic [STP_CNT_W-1:0] stp_last_q, stp_last_d;
  logic [STP_CNT_W-1:0] stp_idx_q, stp_idx_d;
  logic                 par_err_q, par_err_d;
  logic                 stp_err_q, stp_err_d;
  logic                 brk_q, brk_d;
  logic [STP_CNT_W-1:0] stp_last_new;
  logic                 done_w;

  // Out-of-range stop counts are clamped into 1..MAX_STOP; stored as the index of the last stop bit.
  always_comb begin
    if (bus.STP_NUM == '0)          stp_last_new = '0;
    else if (bus.STP_NUM > STP_MAX) stp_last_new = STP_MAX - STP_ONE;
    else                            stp_last_new = bus.STP_NUM - STP_ONE;
  end

  always_comb begin
    state_d    = state_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_bit_d  = par_bit_q;
    stp_last_d = stp_last_q;
    stp_idx_d  = stp_idx_q;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    brk_d      = brk_q;
    if (bus.frame_start) begin
      state_d    = bus.PAR_EN ? ST_PAR : ST_STP;
      par_en_d   = bus.PAR_EN;
      par_typ_d  = bus.PAR_TYP;
      par_bit_d  = 1'b0;
      stp_last_d = stp_last_new;
      stp_idx_d  = '0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
      brk_d      = 1'b0;
    end else begin
      case (state_q)
        ST_PAR: begin
          if (bus.par_chk_en) begin
            par_bit_d = bus.sampled_bit;
            par_err_d = bus.sampled_bit != par_expected(^bus.P_DATA, par_typ_q);
            state_d   = ST_STP;
          end
        end
        ST_STP: begin
          if (bus.stp_chk_en) begin
            stp_err_d = stp_err_q | ~bus.sampled_bit;
            if (stp_idx_q == '0) begin
              brk_d = (bus.P_DATA == '0) && !bus.sampled_bit && (!par_en_q || !par_bit_q);
            end
            stp_idx_d = stp_idx_q + STP_ONE;
            if (stp_idx_q == stp_last_q) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_bit_q  <= 1'b0;
      stp_last_q <= '0;
      stp_idx_q  <= '0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_bit_q  <= par_bit_d;
      stp_last_q <= stp_last_d;
      stp_idx_q  <= stp_idx_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
      brk_q      <= brk_d;
    end
  end

  assign done_w         = (state_q == ST_DONE);
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.brk_det    = brk_q;
  assign bus.frame_done = done_w;
  assign bus.frame_ok   = done_w & ~(par_err_q | stp_err_q | brk_q);

`ifdef FRAME_CHK_ERR_CNT_EN
  sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .inc_i   (done_w & par_err_q),
    .clr_i   (bus.cnt_clr),
    .count_o (bus.par_err_cnt)
  );

  sat_cnt #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST),
    .inc_i   (done_w & stp_err_q),
    .clr_i   (bus.cnt_clr),
    .count_o (bus.stp_err_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr  = bus.cnt_clr;
  assign bus.par_err_cnt = '0;
  assign bus.stp_err_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_chk.sv
// Bench for frame_chk: fixed vector table, randomized frames against a frame-level model, corner sequences.
module tb_frame_chk;

  localparam int DW = 8;
  localparam int MS = 2;
  localparam int CW = 2;
`ifdef FRAME_CHK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    bit       par_en;
    bit       typ;
    bit [1:0] stp;
    bit [7:0] data;
    bit       par_bit;
    bit [1:0] stops;   // stops[0] is the first stop bit on the wire
  } frame_t;

  typedef struct {
    bit par_err;
    bit stp_err;
    bit brk;
    bit ok;
  } exp_t;

  typedef struct {
    frame_t f;
    exp_t   e;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   par_cnt_m = 0;
  int   stp_cnt_m = 0;
  vec_t tbl[10];

  always #5 CLK = ~CLK;

  frame_chk_if #(.DATA_WIDTH(DW), .MAX_STOP(MS), .ERR_CNT_WIDTH(CW)) bus ();

  frame_chk #(.DATA_WIDTH(DW), .MAX_STOP(MS), .ERR_CNT_WIDTH(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic int eff_stops(input bit [1:0] s);
    if (s == 2'd0) return 1;
    if (int'(s) > MS) return MS;
    return int'(s);
  endfunction

  function automatic exp_t model(input frame_t f);
    exp_t e;
    int   n;
    n = eff_stops(f.stp);
    e.par_err = f.par_en && (f.par_bit != ((^f.data) ^ f.typ));
    e.stp_err = 1'b0;
    for (int i = 0; i < n; i++) if (!f.stops[i]) e.stp_err = 1'b1;
    e.brk = (f.data == 8'h00) && !f.stops[0] && (!f.par_en || !f.par_bit);
    e.ok  = !(e.par_err || e.stp_err || e.brk);
    return e;
  endfunction

  function automatic vec_t mkv(input bit pe, input bit ty, input bit [1:0] sn, input bit [7:0] d,
                               input bit pb, input bit [1:0] st,
                               input bit ep, input bit es, input bit eb, input bit eo);
    vec_t v;
    v.f = '{par_en: pe, typ: ty, stp: sn, data: d, par_bit: pb, stops: st};
    v.e = '{par_err: ep, stp_err: es, brk: eb, ok: eo};
    return v;
  endfunction

  function automatic int sat_inc(input int c);
    return (c < (1 << CW) - 1) ? c + 1 : c;
  endfunction

  task automatic clear_inputs();
    bus.frame_start = 1'b0;
    bus.sampled_bit = 1'b1;
    bus.par_chk_en  = 1'b0;
    bus.stp_chk_en  = 1'b0;
    bus.cnt_clr     = 1'b0;
  endtask

  task automatic chk_counts(input string name);
    chk({name, "_par_cnt"}, 32'(bus.par_err_cnt), CNT_EN ? par_cnt_m : 0);
    chk({name, "_stp_cnt"}, 32'(bus.stp_err_cnt), CNT_EN ? stp_cnt_m : 0);
  endtask

  // Cycle following the frame_done cycle: pulse must drop, flags hold, counters reflect the frame.
  task automatic done_tail(input exp_t e, input bit clr);
    bus.cnt_clr = clr;
    cyc();
    bus.cnt_clr = 1'b0;
    if (clr) begin
      par_cnt_m = 0;
      stp_cnt_m = 0;
    end else begin
      if (e.par_err) par_cnt_m = sat_inc(par_cnt_m);
      if (e.stp_err) stp_cnt_m = sat_inc(stp_cnt_m);
    end
    chk("done_one_cycle", {31'd0, bus.frame_done}, 0);
    chk("ok_outside_done", {31'd0, bus.frame_ok}, 0);
    chk("flags_hold", {29'd0, bus.par_err, bus.stp_err, bus.brk_det}, {29'd0, e.par_err, e.stp_err, e.brk});
    chk_counts("tail");
  endtask

  task automatic start(input frame_t f);
    bus.frame_start = 1'b1;
    bus.PAR_EN      = f.par_en;
    bus.PAR_TYP     = f.typ;
    bus.STP_NUM     = f.stp;
    bus.P_DATA      = f.data;
  endtask

  task automatic run_frame(input frame_t f, input exp_t e, input int gap, input bit clr_at_done);
    int n;
    n = eff_stops(f.stp);
    start(f);
    cyc();
    bus.frame_start = 1'b0;
    chk("start_clears", {28'd0, bus.par_err, bus.stp_err, bus.brk_det, bus.frame_done}, 0);
    repeat (gap) cyc();
    if (f.par_en) begin
      bus.par_chk_en  = 1'b1;
      bus.sampled_bit = f.par_bit;
      cyc();
      bus.par_chk_en = 1'b0;
      chk("par_err", {31'd0, bus.par_err}, {31'd0, e.par_err});
    end
    for (int i = 0; i < n; i++) begin
      bus.stp_chk_en  = 1'b1;
      bus.sampled_bit = f.stops[i];
      cyc();
      bus.stp_chk_en  = 1'b0;
      bus.sampled_bit = 1'b1;
      if (i < n - 1) begin
        chk("no_early_done", {31'd0, bus.frame_done}, 0);
        repeat (gap) cyc();
      end
    end
    chk("frame_done", {31'd0, bus.frame_done}, 1);
    chk("frame_ok", {31'd0, bus.frame_ok}, {31'd0, e.ok});
    chk("flags_at_done", {29'd0, bus.par_err, bus.stp_err, bus.brk_det}, {29'd0, e.par_err, e.stp_err, e.brk});
    done_tail(e, clr_at_done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    frame_t f;
    exp_t   e;

    clear_inputs();
    bus.P_DATA  = '0;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.STP_NUM = '0;

    //              pe ty sn    data   pb stops  | par stp brk ok
    tbl[0] = mkv(1, 0, 2'd1, 8'hA5, 0, 2'b01,   0, 0, 0, 1);
    tbl[1] = mkv(1, 1, 2'd1, 8'h01, 1, 2'b01,   1, 0, 0, 0);
    tbl[2] = mkv(0, 0, 2'd2, 8'h3C, 0, 2'b01,   0, 1, 0, 0);
    tbl[3] = mkv(1, 0, 2'd1, 8'h00, 0, 2'b00,   0, 1, 1, 0);
    tbl[4] = mkv(0, 0, 2'd0, 8'hFF, 0, 2'b10,   0, 1, 0, 0);
    tbl[5] = mkv(0, 0, 2'd3, 8'h00, 0, 2'b10,   0, 1, 1, 0);
    tbl[6] = mkv(1, 1, 2'd2, 8'h00, 0, 2'b11,   1, 0, 0, 0);
    tbl[7] = mkv(1, 1, 2'd2, 8'h00, 0, 2'b00,   1, 1, 1, 0);
    tbl[8] = mkv(1, 0, 2'd2, 8'h7F, 1, 2'b11,   0, 0, 0, 1);
    tbl[9] = mkv(0, 1, 2'd2, 8'h80, 0, 2'b11,   0, 0, 0, 1);

    cyc();
    cyc();
    chk("reset_flags", {27'd0, bus.par_err, bus.stp_err, bus.brk_det, bus.frame_done, bus.frame_ok}, 0);
    chk("reset_cnts", {28'd0, bus.par_err_cnt, bus.stp_err_cnt}, 0);
    RST = 1'b1;
    cyc();

    for (int v = 0; v < 10; v++) run_frame(tbl[v].f, tbl[v].e, 1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      f.par_en  = 1'($urandom_range(0, 1));
      f.typ     = 1'($urandom_range(0, 1));
      f.stp     = 2'($urandom_range(0, 3));
      f.data    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      f.par_bit = 1'($urandom_range(0, 1));
      f.stops   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      run_frame(f, model(f), int'($urandom_range(0, 2)), 1'b0);
    end

    // Abort mid-STP: break frame, then frame_start (with a stray stop strobe) re-arms with new config.
    f = '{par_en: 0, typ: 0, stp: 2'd2, data: 8'h00, par_bit: 0, stops: 2'b00};
    start(f);
    cyc();
    bus.frame_start = 1'b0;
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    bus.stp_chk_en = 1'b0;
    chk("abort_pre_flags", {29'd0, bus.par_err, bus.stp_err, bus.brk_det}, 3'b011);
    f = '{par_en: 1, typ: 0, stp: 2'd1, data: 8'hA5, par_bit: 0, stops: 2'b01};
    start(f);
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    clear_inputs();
    chk("abort_clears", {28'd0, bus.par_err, bus.stp_err, bus.brk_det, bus.frame_done}, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("abort_no_done", {31'd0, bus.frame_done}, 0);
    end
    // Stop strobe in PAR is ignored.
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    bus.stp_chk_en = 1'b0;
    chk("stp_in_par_ignored", {30'd0, bus.stp_err, bus.frame_done}, 0);
    // Both strobes in PAR: only parity honoured (sampled 0 is the correct even parity for A5).
    bus.par_chk_en  = 1'b1;
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    clear_inputs();
    chk("both_strobes_par", {29'd0, bus.par_err, bus.stp_err, bus.frame_done}, 0);
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b1;
    cyc();
    clear_inputs();
    chk("rearm_done", {30'd0, bus.frame_done, bus.frame_ok}, 2'b11);
    done_tail('{par_err: 0, stp_err: 0, brk: 0, ok: 1}, 1'b0);

    // frame_start with par_chk_en in the same cycle: the parity strobe is dropped, FSM stays in PAR.
    f = '{par_en: 1, typ: 1, stp: 2'd1, data: 8'h01, par_bit: 1, stops: 2'b01};
    start(f);
    bus.par_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    clear_inputs();
    chk("start_par_same_cycle", {31'd0, bus.par_err}, 0);
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b1;
    cyc();
    clear_inputs();
    chk("still_in_par", {31'd0, bus.frame_done}, 0);
    bus.par_chk_en  = 1'b1;
    bus.sampled_bit = 1'b1;
    cyc();
    clear_inputs();
    chk("late_par_err", {31'd0, bus.par_err}, 1);
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b1;
    cyc();
    clear_inputs();
    chk("late_done", {30'd0, bus.frame_done, bus.frame_ok}, 2'b10);
    done_tail('{par_err: 1, stp_err: 0, brk: 0, ok: 0}, 1'b0);

    // Counters: clear, clear-wins-over-increment, then saturation after 5 parity-error frames.
    bus.cnt_clr = 1'b1;
    cyc();
    bus.cnt_clr = 1'b0;
    par_cnt_m = 0;
    stp_cnt_m = 0;
    chk_counts("cnt_clr");
    f = '{par_en: 1, typ: 0, stp: 2'd1, data: 8'h01, par_bit: 0, stops: 2'b00};
    run_frame(f, model(f), 0, 1'b1);
    for (int k = 0; k < 5; k++) run_frame(f, model(f), 0, 1'b0);
    chk("par_cnt_sat", 32'(bus.par_err_cnt), CNT_EN ? 3 : 0);

    // Async reset mid-frame.
    f = '{par_en: 0, typ: 0, stp: 2'd2, data: 8'h00, par_bit: 0, stops: 2'b00};
    start(f);
    cyc();
    bus.frame_start = 1'b0;
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b0;
    cyc();
    clear_inputs();
    #2;
    RST = 1'b0;
    #1;
    par_cnt_m = 0;
    stp_cnt_m = 0;
    chk("arst_flags", {27'd0, bus.par_err, bus.stp_err, bus.brk_det, bus.frame_done, bus.frame_ok}, 0);
    chk_counts("arst");
    #2;
    RST = 1'b1;
    cyc();
    bus.stp_chk_en  = 1'b1;
    bus.sampled_bit = 1'b1;
    cyc();
    clear_inputs();
    chk("arst_no_done", {31'd0, bus.frame_done}, 0);
    cyc();
    chk("arst_idle_quiet", {28'd0, bus.par_err, bus.stp_err, bus.brk_det, bus.frame_done}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
